swd_target_model: RTL and testbench
===================================

Name: swd_target_model

Overview:
- Synthesizable SWD target (slave) responder, clocked by the system clock; oversamples the host SWCLK.
- Successor to the ad-hoc SWD target model used in the DAP SWJ benches. Adds:
  - parametrised turnaround length and register file;
  - runtime WAIT injection and forced FAULT;
  - header and data parity checking with sticky error;
  - optional line-reset detection.
- Sits opposite DAP_SWJ in SWD benches and in FPGA loopback self-test builds.

Parameters:
- TURN_CYCLES, 1, turnaround length in SWCLK cycles (1..4) for both TURN1 and TURN2.
- NUM_REGS, 8, register file depth, indexed by {APnDP,A3,A2}; must be 8.
- IDCODE, 32'h0BC11477, value returned on a DP read of address 0.

Ports:
- clk  in  1  system clock; must be at least 4x SWCLK.
- reset  in  1  asynchronous, active-high reset.
- swclk_i  in  1  host SWCLK, asynchronous to clk.
- swdio_i  in  1  resolved line value from the host (1 when the host is tri-stated).
- swdio_o  out  1  target drive value.
- swdio_oe  out  1  target output enable.
- wait_count  in  4  number of WAIT ACKs returned before OK, per transfer.
- force_fault  in  1  return FAULT ACK while high.
- req_valid  out  1  one-clk pulse on each completed OK transfer.
- req_apndp  out  1  APnDP of the last request.
- req_rnw  out  1  RnW of the last request.
- req_addr  out  2  {A3,A2} of the last request.
- req_data  out  32  data written or read on the last OK transfer.
- sticky_err  out  1  write-data parity error latched.
- xfer_count  out  16  count of OK transfers; wraps at 0xFFFF->0.

Behaviour:
- Reset values: all outputs 0; register file all 0; state IDLE.
- Edge detection:
  - swclk_i passes through a 2-FF synchronizer, then an edge detector.
  - Line sampled on the detected rising edge (rise).
  - swdio_o/swdio_oe update on the clk after rise, so they are valid at the next host rising edge.
- States, each advanced only on rise:
  - IDLE: wait for swdio_i=1 (start bit), then go to HDR.
  - HDR: collect 7 bits in order APnDP, RnW, A2, A3, Par, Stop, Park.
    - Protocol error: Par != XOR(APnDP,RnW,A2,A3), Stop != 0, or Park != 1.
    - On protocol error: return to IDLE without driving.
    - Otherwise go to TURN1.
  - TURN1: TURN_CYCLES cycles, oe=0. Then go to ACK.
  - ACK: drive 3 bits LSB first; oe=1 from the first ACK bit.
    - Priority: force_fault or sticky_err -> FAULT 3'b100; else waits_done < wait_count -> WAIT 3'b010; else OK 3'b001.
  - After ACK:
    - OK read: go to RDATA.
    - OK write: go to TURN2W.
    - WAIT/FAULT: go to TURN2E.
  - RDATA: drive 32 bits LSB first, then even parity bit. Read source:
    - DP addr 0 returns IDCODE.
    - Any other index returns reg[{APnDP,A3,A2}].
    - Then go to TURN2E.
  - TURN2W: TURN_CYCLES cycles, oe=0. Then go to WDATA.
  - WDATA: sample 32 bits LSB first plus parity.
    - Parity OK: write reg[index] and pulse req_valid. A DP addr 0 write with bit[3]=1 instead clears sticky_err (ABORT/WDERRCLR) and is not stored.
    - Parity error: discard the write and set sticky_err.
    - Then go to IDLE.
  - TURN2E: TURN_CYCLES cycles, oe=0, then go to IDLE.
    - Read-OK exit pulses req_valid.
    - WAIT exit increments waits_done.
- waits_done clears on any OK ACK and on reset.
- xfer_count increments with each req_valid.
- swdio_oe=0 in every state except ACK and RDATA.
- Reset mid-transfer: immediate return to IDLE; oe=0.
- clk cycles without rise hold all state.

Optional Feature:
- Macro: SWD_TARGET_LINE_RESET_EN.
- When defined:
  - A 6-bit counter counts consecutive sampled 1s in any state where oe=0.
  - At 50, force IDLE, clear sticky_err and waits_done, and set oe=0.
  - The counter saturates until a 0 is sampled.
- When undefined: no counter is built; a stream of 1s is only interpreted by the state machine.

Decomposition:
- Package swd_target_pkg holds:
  - state encoding;
  - ACK_OK/ACK_WAIT/ACK_FAULT constants;
  - DP_IDCODE_IDX and ABORT_WDERRCLR_BIT;
  - the parity32 function.
- Sub-module swd_edge_sync: 2-FF synchronizer plus rise/fall pulse generation.

Test Plan:
- DP read of addr 0, wait_count=0 -> ACK 001 then 0x0BC11477 with parity 0; req_valid=1; xfer_count=1.
- AP write of addr 1 (index 5) with data 0xDEADBEEF, then read of the same index -> read returns 0xDEADBEEF with parity 0.
- wait_count=2, AP read -> first two attempts get ACK 010 with oe dropping after TURN2; third attempt gets ACK 001 with data; waits_done returns to 0.
- Write with a flipped data parity bit -> reg unchanged and sticky_err=1; next request gets ACK 100; DP addr 0 write of 0x00000008 clears sticky_err; next read gets ACK 001.
- Header with a bad parity bit -> oe stays 0 for the whole response window; returns to IDLE; xfer_count unchanged.
- With SWD_TARGET_LINE_RESET_EN: 50 ones sent mid-HDR -> state IDLE and sticky_err cleared; without the macro, the same stimulus leaves sticky_err set.

Source files
------------

// File: rtl/swd_target_pkg.sv
// Shared state encoding, ACK codes, register-index constants and the data
// parity helper for the SWD target responder.
package swd_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_TURN1  = 3'd2,
    ST_ACK    = 3'd3,
    ST_RDATA  = 3'd4,
    ST_TURN2W = 3'd5,
    ST_WDATA  = 3'd6,
    ST_TURN2E = 3'd7
  } swd_state_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam logic [2:0]  DP_IDCODE_IDX      = 3'd0;
  localparam int unsigned ABORT_WDERRCLR_BIT = 3;

  function automatic logic parity32(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/swd_edge_sync.sv
// Two-flop synchronizer for the host SWCLK followed by registered
// single-cycle rise/fall pulses in the clk domain.
module swd_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;
  logic rise_d;
  logic fall_d;

  // Edge decode between the synchronized level and its one-clk-old copy.
  always_comb begin
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  // Synchronizer chain and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/swd_target_model.sv
// SWD target responder oversampling the host SWCLK on the system clock.
// Optional line-reset detection is built when SWD_TARGET_LINE_RESET_EN is defined.
module swd_target_model
  import swd_target_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [31:0] IDCODE      = 32'h0BC11477
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swclk_i,
  input  logic        swdio_i,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic [3:0]  wait_count,
  input  logic        force_fault,
  output logic        req_valid,
  output logic        req_apndp,
  output logic        req_rnw,
  output logic [1:0]  req_addr,
  output logic [31:0] req_data,
  output logic        sticky_err,
  output logic [15:0] xfer_count
);

  localparam logic [5:0] TURN_LAST = 6'(TURN_CYCLES - 1);

  logic        rise_s;
  logic        unused_fall_s;

  swd_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  hdr_q, hdr_d;
  logic [2:0]  ack_q, ack_d;
  logic [31:0] shreg_q, shreg_d;
  logic [3:0]  waits_done_q, waits_done_d;
  logic        swdio_o_q, swdio_o_d;
  logic        oe_q, oe_d;
  logic        req_valid_q, req_valid_d;
  logic        req_apndp_q, req_apndp_d;
  logic        req_rnw_q, req_rnw_d;
  logic [1:0]  req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic        sticky_q, sticky_d;
  logic [15:0] xfer_q, xfer_d;
  logic [31:0] regs_q [NUM_REGS];
  logic        reg_we_s;
  logic [2:0]  idx_s;
  logic [31:0] rdata_s;
  logic        abort_wr_s;
  logic        hdr_ok_s;
`ifdef SWD_TARGET_LINE_RESET_EN
  logic [5:0]  lr_cnt_q, lr_cnt_d;
`endif

  swd_edge_sync u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (swclk_i),
    .rise_o  (rise_s),
    .fall_o  (unused_fall_s)
  );

  assign idx_s      = {req_apndp_q, req_addr_q};
  assign rdata_s    = (idx_s == DP_IDCODE_IDX) ? IDCODE : regs_q[idx_s];
  // DP ABORT writes bypass the sticky FAULT so the host can always clear it.
  assign abort_wr_s = ~req_apndp_q & ~req_rnw_q & (req_addr_q == 2'b00);
  assign hdr_ok_s   = (hdr_q[4] == (hdr_q[0] ^ hdr_q[1] ^ hdr_q[2] ^ hdr_q[3]))
                      & ~hdr_q[5] & swdio_i;

  // Next-state logic; every transition is qualified by a sampled SWCLK rise.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    ack_d        = ack_q;
    shreg_d      = shreg_q;
    waits_done_d = waits_done_q;
    swdio_o_d    = swdio_o_q;
    oe_d         = oe_q;
    req_valid_d  = 1'b0;
    req_apndp_d  = req_apndp_q;
    req_rnw_d    = req_rnw_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    sticky_d     = sticky_q;
    xfer_d       = xfer_q;
    reg_we_s     = 1'b0;
    if (rise_s) begin
      case (state_q)
        ST_IDLE: begin
          if (swdio_i) begin
            state_d = ST_HDR;
            cnt_d   = 6'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (cnt_q == 6'd6) begin
            cnt_d = 6'd0;
            if (hdr_ok_s) begin
              state_d     = ST_TURN1;
              req_apndp_d = hdr_q[0];
              req_rnw_d   = hdr_q[1];
              req_addr_d  = {hdr_q[3], hdr_q[2]};
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            hdr_d[cnt_q[2:0]] = swdio_i;
            cnt_d             = cnt_q + 6'd1;
          end
        end
        ST_TURN1: begin
          if (cnt_q == TURN_LAST) begin
            state_d = ST_ACK;
            cnt_d   = 6'd0;
            oe_d    = 1'b1;
            if (force_fault || (sticky_q && !abort_wr_s)) begin
              ack_d = ACK_FAULT;
            end else if (waits_done_q < wait_count) begin
              ack_d = ACK_WAIT;
            end else begin
              ack_d        = ACK_OK;
              waits_done_d = 4'd0;
            end
            swdio_o_d = ack_d[0];
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_ACK: begin
          if (cnt_q == 6'd2) begin
            cnt_d = 6'd0;
            if (ack_q == ACK_OK && req_rnw_q) begin
              state_d   = ST_RDATA;
              shreg_d   = rdata_s;
              swdio_o_d = rdata_s[0];
              oe_d      = 1'b1;
            end else if (ack_q == ACK_OK) begin
              state_d   = ST_TURN2W;
              swdio_o_d = 1'b0;
              oe_d      = 1'b0;
            end else begin
              state_d   = ST_TURN2E;
              swdio_o_d = 1'b0;
              oe_d      = 1'b0;
            end
          end else begin
            cnt_d     = cnt_q + 6'd1;
            swdio_o_d = cnt_q[0] ? ack_q[2] : ack_q[1];
          end
        end
        ST_RDATA: begin
          if (cnt_q == 6'd32) begin
            state_d   = ST_TURN2E;
            cnt_d     = 6'd0;
            swdio_o_d = 1'b0;
            oe_d      = 1'b0;
          end else if (cnt_q == 6'd31) begin
            cnt_d     = cnt_q + 6'd1;
            swdio_o_d = parity32(shreg_q);
          end else begin
            cnt_d     = cnt_q + 6'd1;
            swdio_o_d = shreg_q[cnt_q[4:0] + 5'd1];
          end
        end
        ST_TURN2W: begin
          if (cnt_q == TURN_LAST) begin
            state_d = ST_WDATA;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_WDATA: begin
          if (cnt_q == 6'd32) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
            if (swdio_i == parity32(shreg_q)) begin
              req_valid_d = 1'b1;
              req_data_d  = shreg_q;
              xfer_d      = xfer_q + 16'd1;
              if (abort_wr_s && shreg_q[ABORT_WDERRCLR_BIT]) begin
                sticky_d = 1'b0;
              end else begin
                reg_we_s = 1'b1;
              end
            end else begin
              sticky_d = 1'b1;
            end
          end else begin
            shreg_d[cnt_q[4:0]] = swdio_i;
            cnt_d               = cnt_q + 6'd1;
          end
        end
        ST_TURN2E: begin
          if (cnt_q == TURN_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
            if (ack_q == ACK_OK) begin
              req_valid_d = 1'b1;
              req_data_d  = shreg_q;
              xfer_d      = xfer_q + 16'd1;
            end else if (ack_q == ACK_WAIT) begin
              waits_done_d = waits_done_q + 4'd1;
            end else begin
              waits_done_d = waits_done_q;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_d     = 6'd0;
          swdio_o_d = 1'b0;
          oe_d      = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
`ifdef SWD_TARGET_LINE_RESET_EN
    // Fifty consecutive undriven-slot ones abandon whatever was in flight.
    if (!rise_s || oe_q || !swdio_i) begin
      lr_cnt_d = rise_s ? 6'd0 : lr_cnt_q;
    end else if (lr_cnt_q == 6'd49) begin
      lr_cnt_d     = 6'd50;
      state_d      = ST_IDLE;
      cnt_d        = 6'd0;
      sticky_d     = 1'b0;
      waits_done_d = 4'd0;
      swdio_o_d    = 1'b0;
      oe_d         = 1'b0;
    end else if (lr_cnt_q == 6'd63) begin
      lr_cnt_d = lr_cnt_q;
    end else begin
      lr_cnt_d = lr_cnt_q + 6'd1;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 6'd0;
      hdr_q        <= 6'd0;
      ack_q        <= 3'd0;
      shreg_q      <= 32'd0;
      waits_done_q <= 4'd0;
      swdio_o_q    <= 1'b0;
      oe_q         <= 1'b0;
      req_valid_q  <= 1'b0;
      req_apndp_q  <= 1'b0;
      req_rnw_q    <= 1'b0;
      req_addr_q   <= 2'd0;
      req_data_q   <= 32'd0;
      sticky_q     <= 1'b0;
      xfer_q       <= 16'd0;
`ifdef SWD_TARGET_LINE_RESET_EN
      lr_cnt_q     <= 6'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      ack_q        <= ack_d;
      shreg_q      <= shreg_d;
      waits_done_q <= waits_done_d;
      swdio_o_q    <= swdio_o_d;
      oe_q         <= oe_d;
      req_valid_q  <= req_valid_d;
      req_apndp_q  <= req_apndp_d;
      req_rnw_q    <= req_rnw_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      sticky_q     <= sticky_d;
      xfer_q       <= xfer_d;
`ifdef SWD_TARGET_LINE_RESET_EN
      lr_cnt_q     <= lr_cnt_d;
`endif
    end
  end

  // Register file, written only by a parity-clean, non-ABORT write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (reg_we_s) begin
      regs_q[idx_s] <= shreg_q;
    end
  end

  assign swdio_o    = swdio_o_q;
  assign swdio_oe   = oe_q;
  assign req_valid  = req_valid_q;
  assign req_apndp  = req_apndp_q;
  assign req_rnw    = req_rnw_q;
  assign req_addr   = req_addr_q;
  assign req_data   = req_data_q;
  assign sticky_err = sticky_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_swd_target_model.sv
// Directed bench for swd_target_model: a host-side SWD bit driver with
// hand-computed expected ACKs, read data, parity and status.
module tb_swd_target_model;

  localparam int TURN = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        swclk_i;
  logic        swdio_i;
  logic        swdio_o;
  logic        swdio_oe;
  logic [3:0]  wait_count;
  logic        force_fault;
  logic        req_valid;
  logic        req_apndp;
  logic        req_rnw;
  logic [1:0]  req_addr;
  logic [31:0] req_data;
  logic        sticky_err;
  logic [15:0] xfer_count;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;

  always #5 clk = ~clk;

  swd_target_model #(
    .TURN_CYCLES (TURN),
    .NUM_REGS    (8),
    .IDCODE      (32'h0BC11477)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .swclk_i     (swclk_i),
    .swdio_i     (swdio_i),
    .swdio_o     (swdio_o),
    .swdio_oe    (swdio_oe),
    .wait_count  (wait_count),
    .force_fault (force_fault),
    .req_valid   (req_valid),
    .req_apndp   (req_apndp),
    .req_rnw     (req_rnw),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .sticky_err  (sticky_err),
    .xfer_count  (xfer_count)
  );

  always @(negedge clk) begin
    if (!reset && req_valid) valid_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One SWCLK period: host drives in the low phase, samples target at the rising edge.
  task automatic slot(input logic din, output logic dout, output logic doe);
    @(negedge clk);
    swclk_i = 1'b0;
    swdio_i = din;
    repeat (8) @(negedge clk);
    swclk_i = 1'b1;
    dout    = swdio_o;
    doe     = swdio_oe;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic apndp, input logic rnw, input logic [1:0] a,
                      input logic [31:0] wdata, input logic bad_par,
                      output logic [2:0] ack, output logic [31:0] rdata,
                      output logic rpar, output logic turn_oe);
    logic d, oe;
    logic [6:0] hdr;
    ack = 3'b000; rdata = 32'd0; rpar = 1'b0; turn_oe = 1'b0;
    hdr = {1'b1, 1'b0, apndp ^ rnw ^ a[0] ^ a[1], a[1], a[0], rnw, apndp};
    slot(1'b1, d, oe);
    for (int i = 0; i < 7; i++) slot(hdr[i], d, oe);
    for (int i = 0; i < TURN; i++) begin
      slot(1'b1, d, oe);
      turn_oe |= oe;
    end
    for (int i = 0; i < 3; i++) begin
      slot(1'b1, d, oe);
      ack[i] = oe ? d : 1'b0;
    end
    if (ack == 3'b001 && rnw) begin
      for (int i = 0; i < 32; i++) begin
        slot(1'b1, d, oe);
        rdata[i] = d;
      end
      slot(1'b1, d, oe);
      rpar = d;
    end
    for (int i = 0; i < TURN; i++) begin
      slot(1'b1, d, oe);
      turn_oe |= oe;
    end
    if (ack == 3'b001 && !rnw) begin
      for (int i = 0; i < 32; i++) slot(wdata[i], d, oe);
      slot((^wdata) ^ bad_par, d, oe);
    end
    repeat (2) slot(1'b0, d, oe);
  endtask

  logic [2:0]  ack;
  logic [31:0] rd;
  logic        rp, toe, d, oe, any_oe;

  initial begin
    reset = 1'b1; swclk_i = 1'b0; swdio_i = 1'b0; wait_count = 4'd0; force_fault = 1'b0;
    repeat (5) @(negedge clk);
    check_vec("rst_oe", {swdio_oe, swdio_o, req_valid, sticky_err}, 32'd0);
    check_vec("rst_req", {req_apndp, req_rnw, req_addr, xfer_count}, 32'd0);
    check_vec("rst_data", req_data, 32'd0);
    reset = 1'b0;
    repeat (3) slot(1'b0, d, oe);

    // DP IDCODE read
    xfer(1'b0, 1'b1, 2'b00, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("idc_ack", ack, 3'b001);
    check_vec("idc_data", rd, 32'h0BC11477);
    check_vec("idc_par", rp, 1'b0);
    check_vec("idc_turn_oe", toe, 1'b0);
    check_vec("idc_valid", valid_cnt, 1);
    check_vec("idc_xfer", xfer_count, 16'd1);
    check_vec("idc_req_data", req_data, 32'h0BC11477);

    // AP write index 5 then read back
    xfer(1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0, ack, rd, rp, toe);
    check_vec("wr5_ack", ack, 3'b001);
    check_vec("wr5_req_data", req_data, 32'hDEADBEEF);
    xfer(1'b1, 1'b1, 2'b01, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("rd5_ack", ack, 3'b001);
    check_vec("rd5_data", rd, 32'hDEADBEEF);
    check_vec("rd5_par", rp, 1'b0);
    check_vec("rd5_req", {req_apndp, req_rnw, req_addr}, 4'b1101);
    check_vec("rd5_xfer", xfer_count, 16'd3);

    // WAIT injection
    wait_count = 4'd2;
    for (int i = 0; i < 2; i++) begin
      xfer(1'b1, 1'b1, 2'b01, 32'd0, 1'b0, ack, rd, rp, toe);
      check_vec("wait_ack", ack, 3'b010);
      check_vec("wait_turn_oe", toe, 1'b0);
      check_vec("wait_idle_oe", swdio_oe, 1'b0);
    end
    xfer(1'b1, 1'b1, 2'b01, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("wait_ok_ack", ack, 3'b001);
    check_vec("wait_ok_data", rd, 32'hDEADBEEF);
    xfer(1'b1, 1'b1, 2'b01, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("wait_rearm_ack", ack, 3'b010);
    wait_count = 4'd0;
    check_vec("wait_xfer", xfer_count, 16'd4);

    // Header with bad parity: DP read addr 0 needs par=1, send 0
    any_oe = 1'b0;
    slot(1'b1, d, oe);
    slot(1'b0, d, oe); slot(1'b1, d, oe); slot(1'b0, d, oe); slot(1'b0, d, oe);
    slot(1'b0, d, oe); slot(1'b0, d, oe); slot(1'b1, d, oe);
    for (int i = 0; i < 6; i++) begin slot(1'b1, d, oe); any_oe |= oe; end
    for (int i = 0; i < 8; i++) begin slot(1'b0, d, oe); any_oe |= oe; end
    check_vec("badhdr_oe", any_oe, 1'b0);
    check_vec("badhdr_xfer", xfer_count, 16'd4);
    check_vec("badhdr_valid", valid_cnt, 4);
    xfer(1'b0, 1'b1, 2'b00, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("badhdr_recover", {ack, rd[3:0]}, {3'b001, 4'h7});

    // Write-data parity error, FAULT, ABORT clear
    xfer(1'b1, 1'b0, 2'b10, 32'h12345678, 1'b1, ack, rd, rp, toe);
    check_vec("perr_ack", ack, 3'b001);
    check_vec("perr_sticky", sticky_err, 1'b1);
    xfer(1'b1, 1'b1, 2'b10, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("fault_ack", ack, 3'b100);
    xfer(1'b0, 1'b0, 2'b00, 32'h00000008, 1'b0, ack, rd, rp, toe);
    check_vec("abort_ack", ack, 3'b001);
    check_vec("abort_sticky", sticky_err, 1'b0);
    xfer(1'b1, 1'b1, 2'b10, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("r6_ack", ack, 3'b001);
    check_vec("r6_unchanged", rd, 32'd0);

    // Forced FAULT
    force_fault = 1'b1;
    xfer(1'b1, 1'b1, 2'b01, 32'd0, 1'b0, ack, rd, rp, toe);
    check_vec("force_fault_ack", ack, 3'b100);
    force_fault = 1'b0;

    // Stream of ones mid-header
    xfer(1'b1, 1'b0, 2'b11, 32'hA5A5A5A5, 1'b1, ack, rd, rp, toe);
    check_vec("lr_pre_sticky", sticky_err, 1'b1);
    slot(1'b1, d, oe); slot(1'b1, d, oe); slot(1'b1, d, oe);
    for (int i = 0; i < 50; i++) slot(1'b1, d, oe);
    for (int i = 0; i < 10; i++) slot(1'b0, d, oe);
    xfer(1'b0, 1'b1, 2'b00, 32'd0, 1'b0, ack, rd, rp, toe);
`ifdef SWD_TARGET_LINE_RESET_EN
    check_vec("lr_sticky", sticky_err, 1'b0);
    check_vec("lr_ack", ack, 3'b001);
`else
    check_vec("lr_sticky", sticky_err, 1'b1);
    check_vec("lr_ack", ack, 3'b100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
